rr_grant_arbiter: RTL and testbench

Round-robin arbiter that shares one resource among 2**N requesters. Internally it holds a binary grant index and expands it to a one-hot grant vector through the existing `decoder` block. Every handover is break-before-make, with one dead cycle, so the design is safe to place in front of shared CDC synchronizer channels. An optional hold timeout stops any single requester from monopolising the resource.

---
 rtl/rr_grant_arbiter_pkg.sv | 17 +
 rtl/rr_grant_arbiter_if.sv | 12 +
 rtl/rr_grant_arbiter_decoder.sv | 9 +
 rtl/rr_grant_arbiter.sv | 53 +++++
 tb/tb_rr_grant_arbiter.sv | 81 ++++++++
 5 files changed

// File: rtl/rr_grant_arbiter_pkg.sv
// arb_pkg: arbiter FSM states, default sizing, and the round-robin search helper
package arb_pkg;
  localparam int N_DEF = 3;
  localparam int MAX_HOLD_DEF = 16;
  localparam int MAX_REQ = 256;
  typedef enum logic [1:0] {IDLE, GRANT, GAP} arb_state_t;
  function automatic logic [7:0] rr_pick(input logic [MAX_REQ-1:0] req, input logic [7:0] last, input int n);
    logic [7:0] r;
    logic [7:0] k;
    r = last;
    for (int i = MAX_REQ; i >= 1; i--) begin
      k = 8'((int'(last) + i) % n);
      if (i <= n && req[k]) r = k;
    end
    return r;
  endfunction
endpackage

// File: rtl/rr_grant_arbiter_if.sv
// rr_grant_arbiter_if: requester bus (req in; gnt/gnt_idx/gnt_valid/timeout out) with master/slave modports
interface rr_grant_arbiter_if
  import arb_pkg::*;
#(parameter int N = N_DEF);
  logic [2**N-1:0] req;
  logic [2**N-1:0] gnt;
  logic [N-1:0] gnt_idx;
  logic gnt_valid;
  logic timeout;
  modport master(output req, input gnt, gnt_idx, gnt_valid, timeout);
  modport slave(input req, output gnt, gnt_idx, gnt_valid, timeout);
endinterface

// File: rtl/rr_grant_arbiter_decoder.sv
// decoder: binary index a (N bits) to one-hot y (2**N bits)
module decoder #(
  parameter int N = 3
) (
  input  logic [N-1:0]    a,
  output logic [2**N-1:0] y
);
  assign y = (2**N)'(1) << a;
endmodule

// File: rtl/rr_grant_arbiter.sv
// rr_grant_arbiter: break-before-make round-robin arbiter with hold timeout; ports clk, rst, bus (slave: req in, gnt/gnt_idx/gnt_valid/timeout out)
module rr_grant_arbiter
  import arb_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input logic clk,
  input logic rst,
  rr_grant_arbiter_if.slave bus
);
  localparam int R = 2**N;
  localparam int CW = MAX_HOLD > 0 ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CW-1:0] LIM = CW'(MAX_HOLD > 0 ? MAX_HOLD - 1 : 0);
  arb_state_t state_q, state_d;
  logic [N-1:0] idx_q, idx_d, last_q, last_d, pick;
  logic [CW-1:0] cnt_q, cnt_d;
  logic timeout_q, timeout_d;
  logic [R-1:0] raw;
  logic any, own, force_rel, start;
  assign pick = N'(rr_pick(MAX_REQ'(bus.req), 8'(last_q), R));
  assign any = |bus.req;
  assign own = bus.req[idx_q];
  assign force_rel = (MAX_HOLD != 0) && own && cnt_q == LIM;
  assign start = state_q != GRANT && any;
  always_comb begin
    state_d = state_q == GRANT ? ((!own || force_rel) ? GAP : GRANT) : (any ? GRANT : IDLE);
    idx_d = start ? pick : idx_q;
    last_d = start ? pick : last_q;
    cnt_d = start ? '0 : (state_q == GRANT && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    timeout_d = state_q == GRANT && force_rel;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      last_q <= N'(R - 1);
      cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
  decoder #(.N(N)) u_dec (.a(idx_q), .y(raw));
  assign bus.gnt_valid = state_q == GRANT;
  assign bus.gnt = bus.gnt_valid ? raw : '0;
  assign bus.gnt_idx = idx_q;
  assign bus.timeout = timeout_q;
endmodule

// File: tb/tb_rr_grant_arbiter.sv
// tb_rr_grant_arbiter: directed scoreboard bench for rr_grant_arbiter (N=3, MAX_HOLD=4)
module tb_rr_grant_arbiter;
  typedef struct {
    logic [7:0] g;
    logic v;
    logic [2:0] i;
    logic t;
    string tag;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  exp_t sb[$];
  rr_grant_arbiter_if #(.N(3)) bus();
  rr_grant_arbiter #(.N(3), .MAX_HOLD(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input string what, input logic [7:0] got, input logic [7:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s %s got %h want %h", tag, what, got, want);
    end
  endtask
  task automatic step(input logic r, input logic [7:0] q, input logic [7:0] g, input logic v,
                      input logic [2:0] i, input logic t, input string tag);
    exp_t e;
    rst = r;
    bus.req = q;
    sb.push_back('{g, v, i, t, tag});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk(e.tag, "gnt", bus.gnt, e.g);
    chk(e.tag, "gnt_valid", 8'(bus.gnt_valid), 8'(e.v));
    chk(e.tag, "gnt_idx", 8'(bus.gnt_idx), 8'(e.i));
    chk(e.tag, "timeout", 8'(bus.timeout), 8'(e.t));
  endtask
  initial begin
    bus.req = 8'h00;
    step(1, 8'hFF, 8'h00, 0, 0, 0, "rst0");
    step(1, 8'hFF, 8'h00, 0, 0, 0, "rst1");
    step(0, 8'hFF, 8'h01, 1, 0, 0, "first_g0");
    step(0, 8'h00, 8'h00, 0, 0, 0, "rel0_gap");
    step(0, 8'h00, 8'h00, 0, 0, 0, "rel0_idle");
    step(0, 8'hA4, 8'h04, 1, 2, 0, "rr_g2a");
    step(0, 8'hA4, 8'h04, 1, 2, 0, "rr_g2b");
    step(0, 8'hA0, 8'h00, 0, 2, 0, "rr_gap2");
    step(0, 8'hA0, 8'h20, 1, 5, 0, "rr_g5a");
    step(0, 8'hA0, 8'h20, 1, 5, 0, "rr_g5b");
    step(0, 8'h80, 8'h00, 0, 5, 0, "rr_gap5");
    step(0, 8'h80, 8'h80, 1, 7, 0, "rr_g7a");
    step(0, 8'h80, 8'h80, 1, 7, 0, "rr_g7b");
    step(0, 8'h00, 8'h00, 0, 7, 0, "rr_gap7");
    step(0, 8'h00, 8'h00, 0, 7, 0, "rr_idle");
    step(0, 8'h81, 8'h01, 1, 0, 0, "wrap_g0");
    step(0, 8'h80, 8'h00, 0, 0, 0, "wrap_gap");
    step(0, 8'h80, 8'h80, 1, 7, 0, "wrap_g7");
    step(0, 8'h00, 8'h00, 0, 7, 0, "wrap_gap7");
    step(0, 8'h00, 8'h00, 0, 7, 0, "wrap_idle");
    step(0, 8'h08, 8'h08, 1, 3, 0, "to_h1");
    step(0, 8'h08, 8'h08, 1, 3, 0, "to_h2");
    step(0, 8'h08, 8'h08, 1, 3, 0, "to_h3");
    step(0, 8'h08, 8'h08, 1, 3, 0, "to_h4");
    step(0, 8'h08, 8'h00, 0, 3, 1, "to_pulse");
    step(0, 8'h08, 8'h08, 1, 3, 0, "to_regrant");
    step(0, 8'h5D, 8'h08, 1, 3, 0, "to_noise1");
    step(0, 8'hF8, 8'h08, 1, 3, 0, "to_noise2");
    step(0, 8'h0F, 8'h08, 1, 3, 0, "to_noise3");
    step(0, 8'h08, 8'h00, 0, 3, 1, "to_pulse2");
    step(0, 8'h00, 8'h00, 0, 3, 0, "to_idle");
    step(0, 8'h40, 8'h40, 1, 6, 0, "rm_g6a");
    step(0, 8'h40, 8'h40, 1, 6, 0, "rm_g6b");
    step(1, 8'h40, 8'h00, 0, 0, 0, "rm_reset");
    step(0, 8'h40, 8'h40, 1, 6, 0, "rm_regrant");
    step(0, 8'h00, 8'h00, 0, 6, 0, "rm_gap");
    step(0, 8'h00, 8'h00, 0, 6, 0, "rm_idle");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
